// File: rtl/beep_sfx_seq.sv
// rtl/beep_sfx_seq.sv - priority-arbitrated multi-note sound-effect sequencer for the game beeper
//
// Plays one of NUM_FX fixed note tables (up, down, score, game over) as a square wave.
// A higher or equal effect ID preempts or restarts the current effect. A lower ID waits in
// a single pending slot, and the last such request wins.
//
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   enable     game-active gate; low clears everything like a reset
//   trig       one-cycle effect request, with fx_id the requested effect
//   busy       an effect is playing
//   active_id  ID of the playing effect
//   note_idx   index of the current note
//   done       one-cycle pulse when an effect ends with nothing pending
//   beep       registered square-wave drive to the beeper
module beep_sfx_seq #(
    parameter int NOTE_TICKS   = 2500000,
    parameter int MAX_NOTES    = 8,
    parameter int NUM_FX       = 4,
    parameter int PERIOD_W     = 20,
    parameter int PERIOD_SHIFT = 0,
    localparam int FX_W        = (NUM_FX > 1) ? $clog2(NUM_FX) : 1,
    localparam int IDX_W       = (MAX_NOTES > 1) ? $clog2(MAX_NOTES) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             trig,
    input  logic [FX_W-1:0]  fx_id,
    output logic             busy,
    output logic [FX_W-1:0]  active_id,
    output logic [IDX_W-1:0] note_idx,
    output logic             done,
    output logic             beep
);

    localparam int CNT_W = ($clog2(NOTE_TICKS) > 24) ? $clog2(NOTE_TICKS) : 24;
    localparam logic [CNT_W-1:0] LAST_TICK = CNT_W'(NOTE_TICKS - 1);

    typedef enum logic {IDLE, PLAY} state_t;

    // Unshifted tone period in clock cycles. A value of 0 is a rest. IDs beyond the table play FX0.
    function automatic logic [31:0] raw_period(input logic [FX_W-1:0] id, input logic [IDX_W-1:0] idx);
        int fx;
        int n;
        fx = (int'(id) < 4) ? int'(id) : 0;
        n  = int'(idx);
        case (fx)
            0: case (n)
                   0: return 32'd190835;
                   1: return 32'd151745;
                   2: return 32'd127551;
                   3: return 32'd95420;
                   default: return 32'd0;
               endcase
            1: case (n)
                   0: return 32'd255102;
                   1: return 32'd303030;
                   2: return 32'd381679;
                   3: return 32'd454545;
                   default: return 32'd0;
               endcase
            2: case (n)
                   0: return 32'd95420;
                   1: return 32'd127551;
                   2: return 32'd95420;
                   default: return 32'd0;
               endcase
            default: case (n)
                   0: return 32'd255102;
                   1: return 32'd0;
                   2: return 32'd303030;
                   3: return 32'd0;
                   4: return 32'd381679;
                   default: return 32'd454545;
               endcase
        endcase
    endfunction

    function automatic logic [IDX_W-1:0] last_idx(input logic [FX_W-1:0] id);
        int fx;
        fx = (int'(id) < 4) ? int'(id) : 0;
        case (fx)
            0, 1:    return IDX_W'(3);
            2:       return IDX_W'(2);
            default: return IDX_W'(7);
        endcase
    endfunction

    state_t            state_q;
    logic [FX_W-1:0]   active_q;
    logic [IDX_W-1:0]  idx_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [PERIOD_W-1:0] phase_q;
    logic              pend_valid_q;
    logic [FX_W-1:0]   pend_id_q;
    logic              done_q;
    logic              beep_q;

    logic [PERIOD_W-1:0] cur_period;
    logic              last_tick;
    logic              last_note;
    logic              take_trig;

    assign cur_period = PERIOD_W'(raw_period(active_q, idx_q) >> PERIOD_SHIFT);
    assign last_tick  = (cnt_q == LAST_TICK);
    assign last_note  = (idx_q == last_idx(active_q));
    // Preempt or restart: the new request outranks or equals the playing effect.
    assign take_trig  = trig && (fx_id >= active_q);

    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            state_q      <= IDLE;
            active_q     <= '0;
            idx_q        <= '0;
            cnt_q        <= '0;
            phase_q      <= '0;
            pend_valid_q <= 1'b0;
            pend_id_q    <= '0;
            done_q       <= 1'b0;
            beep_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            beep_q <= (state_q == PLAY) && (cur_period != '0) && (phase_q >= (cur_period >> 1));
            case (state_q)
                IDLE: begin
                    if (trig) begin
                        state_q  <= PLAY;
                        active_q <= fx_id;
                        idx_q    <= '0;
                        cnt_q    <= '0;
                        phase_q  <= '0;
                    end
                end
                PLAY: begin
                    if (take_trig) begin
                        active_q <= fx_id;
                        idx_q    <= '0;
                        cnt_q    <= '0;
                        phase_q  <= '0;
                    end else begin
                        if (trig) begin
                            pend_valid_q <= 1'b1;
                            pend_id_q    <= fx_id;
                        end
                        if (last_tick) begin
                            cnt_q   <= '0;
                            phase_q <= '0;
                            if (!last_note) begin
                                idx_q <= idx_q + IDX_W'(1);
                            end else if (trig) begin
                                // A lower request arriving on the final tick goes straight through the pending slot.
                                active_q     <= fx_id;
                                idx_q        <= '0;
                                pend_valid_q <= 1'b0;
                            end else if (pend_valid_q) begin
                                active_q     <= pend_id_q;
                                idx_q        <= '0;
                                pend_valid_q <= 1'b0;
                            end else begin
                                state_q  <= IDLE;
                                active_q <= '0;
                                idx_q    <= '0;
                                done_q   <= 1'b1;
                            end
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                            if (cur_period == '0 || phase_q == cur_period - PERIOD_W'(1)) begin
                                phase_q <= '0;
                            end else begin
                                phase_q <= phase_q + PERIOD_W'(1);
                            end
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy      = (state_q == PLAY);
    assign active_id = active_q;
    assign note_idx  = idx_q;
    assign done      = done_q;
    assign beep      = beep_q;

endmodule

// File: doc/beep_sfx_seq.md
Name: beep_sfx_seq

Overview:
- Parameterised sound-effect sequencer for the game beeper. It plays one of NUM_FX fixed multi-note effects: up move, down move, score and game over.
- Each effect is triggered by a pulse carrying an effect ID.
- Effects are arbitrated by priority, and one lower-priority request is held in a single pending slot.
- Sits between the game FSM (triggers, game-active enable) and the board beeper pin.

Parameters:
- NOTE_TICKS, 2500000, clock cycles per note (25 ms at 100 MHz).
- MAX_NOTES, 8, maximum notes per effect; note index width is clog2(MAX_NOTES).
- NUM_FX, 4, number of effects; ID width FX_W = clog2(NUM_FX).
- PERIOD_W, 20, tone period counter width.
- PERIOD_SHIFT, 0, right-shift applied to every table period; used for fast simulation.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- enable  in  1  game-active gate; low acts as a synchronous clear
- trig  in  1  one-cycle effect request
- fx_id  in  FX_W  requested effect, sampled when trig=1
- busy  out  1  an effect is playing
- active_id  out  FX_W  ID of the playing effect
- note_idx  out  clog2(MAX_NOTES)  current note index
- done  out  1  one-cycle pulse when an effect ends and nothing is pending
- beep  out  1  square-wave drive to the beeper

Behaviour:
- Effect table (period in cycles, then >> PERIOD_SHIFT; a period of 0 is a rest):
  - FX0 up: 190835, 151745, 127551, 95420 (4 notes).
  - FX1 down: 255102, 303030, 381679, 454545 (4 notes).
  - FX2 score: 95420, 127551, 95420 (3 notes).
  - FX3 game over: 255102, 0, 303030, 0, 381679, 454545, 454545, 454545 (8 notes).
  - IDs >= 4 (when NUM_FX > 4) map to FX0.
- Reset, or enable=0, clears all state and forces every output to 0. Triggers are ignored while either applies. This clear takes effect mid-effect in the same cycle.
- States: IDLE and PLAY. The pending slot is a separate register: pend_valid and pend_id.
- IDLE, trig=1 at cycle t:
  - At t+1: busy=1, active_id=fx_id, note_idx=0, note counter=0, phase=0.
- PLAY, trig=1, arbitration by numeric priority (higher ID wins):
  - fx_id > active_id: preempt. Restart at note 0 with the new ID next cycle. Pending is untouched.
  - fx_id == active_id: restart the same effect at note 0.
  - fx_id < active_id: write it to the pending slot, overwriting any previous entry (last wins).
- Note timing:
  - Each note lasts exactly NOTE_TICKS cycles.
  - On the last cycle of note k, the next cycle starts note k+1 with phase reset to 0.
  - An N-note effect with no interruption holds busy high for exactly N*NOTE_TICKS cycles.
- End of the final note:
  - If pend_valid: the next cycle starts pend_id at note 0, pend_valid clears, busy stays 1 and no done pulse is issued.
  - Otherwise: the state returns to IDLE, busy=0, and done=1 for one cycle.
- Simultaneous trig and final-note end: the trig is arbitrated against the finishing effect as above. A preempt or restart wins over pending, which is retained. A lower-ID trig overwrites pending, and that effect then starts next.
- Tone generation:
  - phase counts 0..P-1 and wraps; P is the current note's shifted period.
  - beep is registered: beep(t+1) = busy(t) and P != 0 and phase(t) >= P>>1.
  - During a rest, or when P == 0 after shifting, beep=0 and phase holds at 0.
  - beep is 0 in the first busy cycle.
- Arithmetic is unsigned. NOTE_TICKS uses a counter of at least 24 bits. The table is truncated to PERIOD_W after the shift.

Test Plan:
- Test parameters for all scenarios: NOTE_TICKS=100, PERIOD_SHIFT=12 (FX0 periods 46, 37, 31, 23).
- Reset and enable:
  - Assert rst mid-FX1 -> next cycle busy=0, beep=0, note_idx=0, done=0.
  - Repeat with enable=0 -> same result.
- Basic FX0, trig at t:
  - busy is 1 for cycles t+1..t+400, and done=1 at t+401.
  - note_idx steps 0, 1, 2, 3 every 100 cycles.
  - In note 0, beep is low for 24 cycles then high for 23, with period 46.
- Preempt: FX1 playing note 2, trig FX3 -> next cycle active_id=3, note_idx=0. Total busy is extended accordingly.
- Pending:
  - FX2 playing; trig FX0, then trig FX1 -> FX1 starts immediately after FX2's 300th cycle and busy stays high.
  - FX0 is never played. A single done pulse occurs at the end of FX1.
- Rests: FX3 -> beep stays 0 throughout notes 1 and 3.
- Simultaneity: trig of the same ID on the final cycle of the effect -> restart at note 0 with no done pulse.
